// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg
// Shared definitions for the post-run data-memory dump block.
// Holds the dump state enumeration and the default address/data widths
// used by mem_dump and mem_dump_csum.
// Optional feature macro used elsewhere in this slice: MEM_DUMP_CHECKSUM_EN.

package mem_dump_pkg;

  localparam int MEM_DUMP_AW = 8;
  localparam int MEM_DUMP_DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } mem_dump_state_t;

endpackage

// File: rtl/mem_dump_csum.sv
// mem_dump_csum
// Running modular byte sum for the optional checksum beat of mem_dump.
// Only instantiated when MEM_DUMP_CHECKSUM_EN is defined.
// Ports:
//   clk_i   - system clock, rising edge
//   reset_i - synchronous active-high reset
//   clr_i   - clears the sum (start of a new dump)
//   en_i    - adds data_i to the sum this cycle
//   data_i  - byte to accumulate
//   sum_o   - current sum, modulo 2^DW

module mem_dump_csum
  import mem_dump_pkg::*;
#(
  parameter int DW = MEM_DUMP_DW
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] sum_o
);

  logic [DW-1:0] sumQ;

  // Clear has priority over accumulate so a new dump never inherits
  // a byte from the previous one; the adder simply drops its carry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sumQ <= '0;
    end else if (clr_i) begin
      sumQ <= '0;
    end else if (en_i) begin
      sumQ <= sumQ + data_i;
    end
  end

  assign sum_o = sumQ;

endmodule

// File: rtl/mem_dump.sv
// mem_dump
// Post-run data-memory reader. When the processor raises done, walks a
// window of data memory through a dedicated combinational read port and
// streams each byte out over a valid/ready interface.
// Optional feature: define MEM_DUMP_CHECKSUM_EN to append one extra beat
// carrying the modular sum of all streamed bytes (out_last moves to it).
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   done_in    - processor done level; its rising edge starts a dump
//   base_addr  - first address of the window, sampled at trigger
//   len        - byte count 0..2^AW, sampled at trigger
//   rd_addr    - address to the data-memory read port
//   rd_data    - read data, valid in the same cycle as rd_addr
//   out_data   - stream byte
//   out_valid  - out_data is valid
//   out_ready  - consumer accepts the byte
//   out_last   - final beat of the dump
//   busy       - dump in progress (STREAM)
//   finished   - dump complete, waiting for done_in to drop (DONE)

module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int AW = MEM_DUMP_AW,
  parameter int DW = MEM_DUMP_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          done_in,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          finished
);

  mem_dump_state_t stateQ, stateD;
  logic            doneQ;
  logic [AW-1:0]   rdAddrQ, rdAddrD;
  logic [AW:0]     remainingQ, remainingD;
  logic [DW-1:0]   outDataQ, outDataD;
  logic            outValidQ, outValidD;
  logic            outLastQ, outLastD;

  logic            trigger;
  logic            canLoad;
  logic            loadData;
  logic            loadCsum;
  logic            lastAccepted;
  logic            csumPendingQ;
  logic [DW-1:0]   csumSum;

  // A dump starts only on a genuine 0->1 transition of done_in seen
  // while idle. The output register may refill whenever it is empty or
  // being drained this very edge, which gives bubble-free streaming.
  assign trigger      = (stateQ == IDLE) && done_in && !doneQ;
  assign canLoad      = (stateQ == STREAM) && (!outValidQ || out_ready);
  assign loadData     = canLoad && (remainingQ != '0);
  assign loadCsum     = canLoad && (remainingQ == '0) && csumPendingQ;
  assign lastAccepted = (stateQ == STREAM) && outValidQ && out_ready && outLastQ;

`ifdef MEM_DUMP_CHECKSUM_EN
  // The checksum beat is owed from trigger until it has been loaded into
  // the output register; while owed, no data beat may carry out_last.
  always_ff @(posedge clk) begin
    if (reset) begin
      csumPendingQ <= 1'b0;
    end else if (trigger) begin
      csumPendingQ <= 1'b1;
    end else if (loadCsum) begin
      csumPendingQ <= 1'b0;
    end
  end

  mem_dump_csum #(
    .DW(DW)
  ) uCsum (
    .clk_i  (clk),
    .reset_i(reset),
    .clr_i  (trigger),
    .en_i   (loadData),
    .data_i (rd_data),
    .sum_o  (csumSum)
  );
`else
  assign csumPendingQ = 1'b0;
  assign csumSum      = '0;
`endif

  // State and datapath registers. During reset the previous-done flag
  // tracks done_in itself, so a done_in already high when reset is
  // released does not look like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= IDLE;
      doneQ      <= done_in;
      rdAddrQ    <= '0;
      remainingQ <= '0;
      outDataQ   <= '0;
      outValidQ  <= 1'b0;
      outLastQ   <= 1'b0;
    end else begin
      stateQ     <= stateD;
      doneQ      <= done_in;
      rdAddrQ    <= rdAddrD;
      remainingQ <= remainingD;
      outDataQ   <= outDataD;
      outValidQ  <= outValidD;
      outLastQ   <= outLastD;
    end
  end

  // Next-state and datapath updates. A data load reads the byte at the
  // current address and advances the address (wrapping naturally at
  // 2^AW); once the data is exhausted the checksum beat, if owed, is
  // loaded the same way. The dump ends when the out_last beat is taken,
  // or immediately when there was nothing at all to send.
  always_comb begin
    stateD     = stateQ;
    rdAddrD    = rdAddrQ;
    remainingD = remainingQ;
    outDataD   = outDataQ;
    outValidD  = outValidQ;
    outLastD   = outLastQ;

    case (stateQ)
      IDLE: begin
        if (trigger) begin
          stateD     = STREAM;
          rdAddrD    = base_addr;
          remainingD = len;
        end
      end

      STREAM: begin
        if (loadData) begin
          outDataD   = rd_data;
          outValidD  = 1'b1;
          outLastD   = (remainingQ == (AW+1)'(1)) && !csumPendingQ;
          rdAddrD    = rdAddrQ + AW'(1);
          remainingD = remainingQ - (AW+1)'(1);
        end else if (loadCsum) begin
          outDataD  = csumSum;
          outValidD = 1'b1;
          outLastD  = 1'b1;
        end else if (outValidQ && out_ready) begin
          outValidD = 1'b0;
          outLastD  = 1'b0;
        end

        if (lastAccepted) begin
          stateD = DONE;
        end else if ((remainingQ == '0) && !outValidQ && !csumPendingQ) begin
          stateD = DONE;
        end
      end

      DONE: begin
        if (!done_in) begin
          stateD = IDLE;
        end
      end

      default: begin
        stateD = IDLE;
      end
    endcase
  end

  assign rd_addr   = rdAddrQ;
  assign out_data  = outDataQ;
  assign out_valid = outValidQ;
  assign out_last  = outLastQ;
  assign busy      = (stateQ == STREAM);
  assign finished  = (stateQ == DONE);

endmodule

// File: tb/tb_mem_dump.sv
// tb_mem_dump
// Directed bench for mem_dump. The memory model answers mem[a] = a ^ 8'h5A
// combinationally. Expected beats are hand-computed per scenario; when
// MEM_DUMP_CHECKSUM_EN is defined the expected checksum beat is appended.

module tb_mem_dump;

  logic       clk = 1'b0;
  logic       reset;
  logic       doneIn;
  logic [7:0] baseAddr;
  logic [8:0] len;
  logic [7:0] rdAddr;
  logic [7:0] rdData;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic       outLast;
  logic       busy;
  logic       finished;

  int         totalChecks = 0;
  int         badChecks   = 0;
  logic [7:0] expBytes [0:15];
  int         expCount;
  logic [3:0] readyPat = 4'b1001;
  int         exitCycle;

  mem_dump dut (
    .clk      (clk),
    .reset    (reset),
    .done_in  (doneIn),
    .base_addr(baseAddr),
    .len      (len),
    .rd_addr  (rdAddr),
    .rd_data  (rdData),
    .out_data (outData),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_last (outLast),
    .busy     (busy),
    .finished (finished)
  );

  always #5 clk = ~clk;

  // Data memory model behind the dedicated read port.
  always_comb begin
    rdData = rdAddr ^ 8'h5A;
  end

  // Step to just after the next rising edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Start a dump and follow it to completion, checking every presented
  // beat against expBytes and its out_last flag against the final index.
  task automatic applyStimulus(input logic [7:0] base, input logic [8:0] n,
                               input bit backpressure, output int exitC);
    int idx;
    int c;
    idx      = 0;
    baseAddr = base;
    len      = n;
    outReady = 1'b1;
    doneIn   = 1'b1;
    tick();
    checkOutput("busyAfterTrigger", 32'(busy), 32'd1);
    checkOutput("validAfterTrigger", 32'(outValid), 32'd0);
    baseAddr = 8'h00;
    len      = 9'd0;
    c        = 0;
    while (c < 64 && !finished) begin
      outReady = backpressure ? readyPat[c % 4] : 1'b1;
      if (outValid) begin
        if (idx < expCount) begin
          checkOutput("beatData", 32'(outData), 32'(expBytes[idx]));
          checkOutput("beatLast", 32'(outLast), (idx == expCount - 1) ? 32'd1 : 32'd0);
        end else begin
          checkOutput("extraBeatIdx", 32'(idx), 32'(expCount - 1));
        end
        if (outReady) idx++;
      end
      tick();
      c++;
    end
    exitC = c;
    checkOutput("beatCount", 32'(idx), 32'(expCount));
    checkOutput("finishedReached", 32'(finished), 32'd1);
  endtask

  // Drop done_in and confirm the block re-arms to idle.
  task automatic endRun();
    doneIn = 1'b0;
    tick();
    checkOutput("rearmFinished", 32'(finished), 32'd0);
    checkOutput("rearmBusy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    doneIn   = 1'b0;
    baseAddr = 8'h00;
    len      = 9'd0;
    outReady = 1'b0;
    tick();
    tick();
    checkOutput("resetValid", 32'(outValid), 32'd0);
    checkOutput("resetData", 32'(outData), 32'd0);
    checkOutput("resetLast", 32'(outLast), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetFinished", 32'(finished), 32'd0);
    checkOutput("resetAddr", 32'(rdAddr), 32'd0);
    reset = 1'b0;
    tick();

    // Basic dump: 0x10..0x13 -> 4A 4B 48 49.
    expBytes[0] = 8'h4A; expBytes[1] = 8'h4B;
    expBytes[2] = 8'h48; expBytes[3] = 8'h49;
    expCount = 4;
`ifdef MEM_DUMP_CHECKSUM_EN
    expBytes[4] = 8'h26;
    expCount = 5;
`endif
    applyStimulus(8'h10, 9'd4, 1'b0, exitCycle);
    checkOutput("basicExitCycle", 32'(exitCycle), 32'(expCount + 1));
    endRun();

    // Backpressure on the same window.
    applyStimulus(8'h10, 9'd4, 1'b1, exitCycle);
    endRun();

    // Wrap: 0xFE, 0xFF, 0x00 -> A4 A5 5A.
    expBytes[0] = 8'hA4; expBytes[1] = 8'hA5; expBytes[2] = 8'h5A;
    expCount = 3;
`ifdef MEM_DUMP_CHECKSUM_EN
    expBytes[3] = 8'hA3;
    expCount = 4;
`endif
    applyStimulus(8'hFE, 9'd3, 1'b0, exitCycle);
    checkOutput("wrapExitCycle", 32'(exitCycle), 32'(expCount + 1));
    checkOutput("wrapAddr", 32'(rdAddr), 32'h01);
    endRun();

    // Empty window.
    expCount = 0;
`ifdef MEM_DUMP_CHECKSUM_EN
    expBytes[0] = 8'h00;
    expCount = 1;
`endif
    applyStimulus(8'h40, 9'd0, 1'b0, exitCycle);
    checkOutput("emptyExitCycle", 32'(exitCycle), 32'(expCount + 1));
    endRun();

    // Two bytes from 0: 5A 5B (checksum B5 when enabled).
    expBytes[0] = 8'h5A; expBytes[1] = 8'h5B;
    expCount = 2;
`ifdef MEM_DUMP_CHECKSUM_EN
    expBytes[2] = 8'hB5;
    expCount = 3;
`endif
    applyStimulus(8'h00, 9'd2, 1'b0, exitCycle);
    checkOutput("pairExitCycle", 32'(exitCycle), 32'(expCount + 1));
    endRun();

    // Reset mid-stream after the second beat of an 8-byte dump.
    baseAddr = 8'h10;
    len      = 9'd8;
    outReady = 1'b1;
    doneIn   = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("preResetData", 32'(outData), 32'h4B);
    reset = 1'b1;
    tick();
    checkOutput("abortValid", 32'(outValid), 32'd0);
    checkOutput("abortData", 32'(outData), 32'd0);
    checkOutput("abortLast", 32'(outLast), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortAddr", 32'(rdAddr), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("noRetriggerBusy", 32'(busy), 32'd0);
    checkOutput("noRetriggerValid", 32'(outValid), 32'd0);
    doneIn = 1'b0;
    tick();

    // Restart from base: 0x10..0x17.
    expBytes[0] = 8'h4A; expBytes[1] = 8'h4B; expBytes[2] = 8'h48; expBytes[3] = 8'h49;
    expBytes[4] = 8'h4E; expBytes[5] = 8'h4F; expBytes[6] = 8'h4C; expBytes[7] = 8'h4D;
    expCount = 8;
`ifdef MEM_DUMP_CHECKSUM_EN
    expBytes[8] = 8'h5C;
    expCount = 9;
`endif
    applyStimulus(8'h10, 9'd8, 1'b0, exitCycle);
    checkOutput("restartExitCycle", 32'(exitCycle), 32'(expCount + 1));
    endRun();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
